// File: rtl/video_mode_controller.sv
// video_mode_controller
//   Selects the active test pattern and video source from two debounced push
//   buttons and muxes the chosen video stream onto the output.
//   Each button runs its own short/long press FSM. Requested changes collect in
//   "pending" registers and are committed to the active registers only at the
//   frame origin (Col = 0, Row = 0), so a mode change never tears a frame.
//
// Ports
//   i_Clk, i_Reset                 clock (rising edge), async active-high reset
//   i_Switch_Pattern/Source        debounced buttons, 1 = pressed
//   i_ColCount, i_RowCount         current pixel position
//   i_TP_*, i_Pong_*               test-pattern and game video
//   o_PatternSelect, o_SourceSelect active (committed) mode
//   o_Video*                       registered, blanked outside the visible area
//   o_FrameStart                   registered one-cycle frame-origin pulse
//   o_Pending                      pending mode differs from active mode
module video_mode_controller #(
    parameter int c_COLOR_BIT_WIDTH  = 3,
    parameter int c_NUM_PATTERNS     = 8,
    parameter int c_LONG_PRESS_CYCLES = 25000000,
    parameter int c_VISIBLE_COLUMNS  = 640,
    parameter int c_VISIBLE_ROWS     = 480
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Switch_Pattern,
    input  logic                         i_Switch_Source,
    input  logic [9:0]                   i_ColCount,
    input  logic [9:0]                   i_RowCount,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_TP_Red,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_TP_Green,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_TP_Blue,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_Pong_Red,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_Pong_Green,
    input  logic [c_COLOR_BIT_WIDTH-1:0] i_Pong_Blue,
    output logic [3:0]                   o_PatternSelect,
    output logic                         o_SourceSelect,
    output logic [c_COLOR_BIT_WIDTH-1:0] o_VideoRed,
    output logic [c_COLOR_BIT_WIDTH-1:0] o_VideoGreen,
    output logic [c_COLOR_BIT_WIDTH-1:0] o_VideoBlue,
    output logic                         o_FrameStart,
    output logic                         o_Pending
);

    localparam int CNT_W = $clog2(c_LONG_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(c_LONG_PRESS_CYCLES - 1);
    localparam logic [3:0] PAT_LAST = 4'(c_NUM_PATTERNS - 1);

    // ST_SUPPRESS behaves like LONG but its release produces no action; it is
    // the reset state so a button held through reset never fires an event.
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG, ST_SUPPRESS} btn_state_t;

    logic [1:0]       btn;          // [0] = pattern, [1] = source
    btn_state_t       btn_state [2];
    logic [CNT_W-1:0] hold_cnt  [2];
    logic [1:0]       short_rel;
    logic [1:0]       long_rel;

    logic [3:0] pend_pat;
    logic       pend_src;
    logic       frame_origin;
    logic       visible;

    assign btn          = {i_Switch_Source, i_Switch_Pattern};
    assign frame_origin = (i_ColCount == 10'd0) && (i_RowCount == 10'd0);
    assign visible      = ({1'b0, i_ColCount} < 11'(c_VISIBLE_COLUMNS)) &&
                          ({1'b0, i_RowCount} < 11'(c_VISIBLE_ROWS));

    // Press classifier FSMs, one per button.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            for (int i = 0; i < 2; i++) begin
                btn_state[i] <= ST_SUPPRESS;
                hold_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (btn_state[i])
                    ST_IDLE: begin
                        hold_cnt[i] <= '0;
                        if (btn[i]) btn_state[i] <= ST_HELD;
                    end
                    ST_HELD: begin
                        if (!btn[i]) begin
                            btn_state[i] <= ST_IDLE;
                        end else if (hold_cnt[i] == LONG_LAST) begin
                            btn_state[i] <= ST_LONG;   // counter holds from here on
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 1'b1;
                        end
                    end
                    ST_LONG, ST_SUPPRESS: begin
                        if (!btn[i]) begin
                            btn_state[i] <= ST_IDLE;
                            hold_cnt[i]  <= '0;
                        end
                    end
                    default: btn_state[i] <= ST_SUPPRESS;
                endcase
            end
        end
    end

    // Release events are decoded from the registered state plus the live button.
    always_comb begin
        short_rel = '0;
        long_rel  = '0;
        for (int i = 0; i < 2; i++) begin
            short_rel[i] = (btn_state[i] == ST_HELD) && !btn[i];
            long_rel[i]  = (btn_state[i] == ST_LONG) && !btn[i];
        end
    end

    // Pending/active mode. The commit reads pend_* as registered before this
    // edge, so a release landing on the origin cycle waits a full frame.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pend_pat        <= 4'd0;
            pend_src        <= 1'b1;
            o_PatternSelect <= 4'd0;
            o_SourceSelect  <= 1'b1;
            o_FrameStart    <= 1'b0;
        end else begin
            if (long_rel[0])
                pend_pat <= 4'd0;
            else if (short_rel[0])
                pend_pat <= (pend_pat == PAT_LAST) ? 4'd0 : pend_pat + 4'd1;

            if (short_rel[1] || long_rel[1])
                pend_src <= ~pend_src;

            if (frame_origin) begin
                o_PatternSelect <= pend_pat;
                o_SourceSelect  <= pend_src;
            end
            o_FrameStart <= frame_origin;
        end
    end

    assign o_Pending = (pend_pat != o_PatternSelect) || (pend_src != o_SourceSelect);

    // Video mux, one clock of latency, blanked outside the active area.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_VideoRed   <= '0;
            o_VideoGreen <= '0;
            o_VideoBlue  <= '0;
        end else if (!visible) begin
            o_VideoRed   <= '0;
            o_VideoGreen <= '0;
            o_VideoBlue  <= '0;
        end else if (o_SourceSelect) begin
            o_VideoRed   <= i_Pong_Red;
            o_VideoGreen <= i_Pong_Green;
            o_VideoBlue  <= i_Pong_Blue;
        end else begin
            o_VideoRed   <= i_TP_Red;
            o_VideoGreen <= i_TP_Green;
            o_VideoBlue  <= i_TP_Blue;
        end
    end

endmodule

// File: tb/tb_video_mode_controller.sv
// Scoreboard bench: stimulus pushes expected values, monitors pop and compare
// on every o_FrameStart pulse and on every probe cycle.
module tb_video_mode_controller;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_p = 1'b0, sw_s = 1'b0;
    logic [9:0]    col = 10'd100, row = 10'd100;
    logic [CW-1:0] tp_r = 3'b010, tp_g = 3'b001, tp_b = 3'b100;
    logic [CW-1:0] pg_r = 3'b101, pg_g = 3'b110, pg_b = 3'b011;
    logic [3:0]    pat;
    logic          src, fs, pend;
    logic [CW-1:0] vr, vg, vb;

    localparam logic [8:0] PONG = 9'b101_110_011;
    localparam logic [8:0] TP   = 9'b010_001_100;

    video_mode_controller #(
        .c_COLOR_BIT_WIDTH(CW), .c_NUM_PATTERNS(8), .c_LONG_PRESS_CYCLES(100),
        .c_VISIBLE_COLUMNS(640), .c_VISIBLE_ROWS(480)
    ) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Switch_Pattern(sw_p), .i_Switch_Source(sw_s),
        .i_ColCount(col), .i_RowCount(row),
        .i_TP_Red(tp_r), .i_TP_Green(tp_g), .i_TP_Blue(tp_b),
        .i_Pong_Red(pg_r), .i_Pong_Green(pg_g), .i_Pong_Blue(pg_b),
        .o_PatternSelect(pat), .o_SourceSelect(src),
        .o_VideoRed(vr), .o_VideoGreen(vg), .o_VideoBlue(vb),
        .o_FrameStart(fs), .o_Pending(pend)
    );

    always #5 clk = ~clk;

    logic [5:0]  fq[$];   // {pat, src, pend} at each frame start
    logic [14:0] pq[$];   // {pat, src, pend, rgb} at each probe
    int          total = 0, bad = 0;
    int          fidx = 0, pidx = 0;
    logic        probe = 1'b0, probe_d = 1'b0;
    logic        done = 1'b0;

    always @(posedge clk) probe_d <= probe;

    always @(negedge clk) if (!done) begin
        if (fs) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL frame_start#%0d unexpected pulse", fidx);
            end else begin
                logic [5:0] e;
                e = fq.pop_front();
                if ({pat, src, pend} !== e) begin
                    bad++;
                    $display("FAIL frame#%0d got pat=%0d src=%0d pend=%0d want pat=%0d src=%0d pend=%0d",
                             fidx, pat, src, pend, e[5:2], e[1], e[0]);
                end
            end
            fidx++;
        end
        if (probe_d) begin
            total++;
            if (pq.size() == 0) begin
                bad++;
                $display("FAIL probe#%0d no expectation queued", pidx);
            end else begin
                logic [14:0] e;
                e = pq.pop_front();
                if ({pat, src, pend, vr, vg, vb} !== e) begin
                    bad++;
                    $display("FAIL probe#%0d got pat=%0d src=%0d pend=%0d rgb=%b want pat=%0d src=%0d pend=%0d rgb=%b",
                             pidx, pat, src, pend, {vr, vg, vb}, e[14:11], e[10], e[9], e[8:0]);
                end
            end
            pidx++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One origin cycle; expectation is checked on the following o_FrameStart.
    task automatic frame(input logic [3:0] p, input logic s, input logic pd);
        fq.push_back({p, s, pd});
        col = 10'd0; row = 10'd0;
        tick();
        col = 10'd100; row = 10'd100;
    endtask

    task automatic probe_at(input int c, input int r, input logic [3:0] p,
                            input logic s, input logic pd, input logic [8:0] rgb);
        pq.push_back({p, s, pd, rgb});
        col = 10'(c); row = 10'(r); probe = 1'b1;
        tick();
        probe = 1'b0; col = 10'd100; row = 10'd100;
    endtask

    // which: 0 = pattern, 1 = source, 2 = both; held for n sampled edges.
    task automatic press(input int which, input int n);
        if (which != 1) sw_p = 1'b1;
        if (which != 0) sw_s = 1'b1;
        repeat (n) tick();
        sw_p = 1'b0; sw_s = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        probe_at(100, 100, 4'd0, 1'b1, 1'b0, 9'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Short press committed only at frame origin
        press(0, 10);
        probe_at(100, 100, 4'd0, 1'b1, 1'b1, PONG);
        frame(4'd1, 1'b1, 1'b0);

        // Pattern wraps 7 -> 0
        for (int k = 2; k <= 8; k++) begin
            press(0, 3);
            frame(4'(k % 8), 1'b1, 1'b0);
        end

        // Long press clears; 99-cycle hold is still short
        repeat (5) press(0, 3);
        frame(4'd5, 1'b1, 1'b0);
        press(0, 150);
        frame(4'd0, 1'b1, 1'b0);
        repeat (5) press(0, 3);
        frame(4'd5, 1'b1, 1'b0);
        press(0, 99);
        frame(4'd6, 1'b1, 1'b0);

        // Source released on the origin cycle commits one frame later
        sw_s = 1'b1;
        repeat (3) tick();
        fq.push_back({4'd6, 1'b1, 1'b1});
        sw_s = 1'b0; col = 10'd0; row = 10'd0;
        tick();
        col = 10'd100; row = 10'd100;
        tick();
        frame(4'd6, 1'b0, 1'b0);

        // Video mux and blanking
        press(1, 3);
        frame(4'd6, 1'b1, 1'b0);
        probe_at(10, 10, 4'd6, 1'b1, 1'b0, PONG);
        probe_at(700, 10, 4'd6, 1'b1, 1'b0, 9'd0);
        probe_at(639, 479, 4'd6, 1'b1, 1'b0, PONG);
        probe_at(10, 480, 4'd6, 1'b1, 1'b0, 9'd0);

        // Reset mid-press, buttons held across deassertion: no event
        sw_p = 1'b1; sw_s = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (200) tick();
        sw_p = 1'b0; sw_s = 1'b0;
        repeat (2) tick();
        probe_at(100, 100, 4'd0, 1'b1, 1'b0, PONG);
        frame(4'd0, 1'b1, 1'b0);

        // Simultaneous releases both take effect
        press(2, 3);
        frame(4'd1, 1'b0, 1'b0);
        probe_at(10, 10, 4'd1, 1'b0, 1'b0, TP);

        repeat (3) tick();
        done = 1'b1;
        total++;
        if (fq.size() != 0 || pq.size() != 0) begin
            bad++;
            $display("FAIL drain leftover frame=%0d probe=%0d want 0 0", fq.size(), pq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
